// File: rtl/decode_writeback_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and status codes.
package y86_defs;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam int unsigned NUM_REGS = 15;

    typedef enum logic [1:0] {
        StatAok = 2'b00,
        StatHlt = 2'b01,
        StatAdr = 2'b10,
        StatIns = 2'b11
    } stat_e;

    // Instructions that may commit architectural state (everything but halt and undefined codes).
    function automatic logic is_committing(input logic [3:0] icode);
        return (icode >= NOP) && (icode <= POPQ);
    endfunction

endpackage

// File: rtl/decode_writeback_if.sv
// Decode/writeback bus: instruction fields and results in, register reads and status out.
interface decode_writeback_if;

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        dmem_error;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [1:0]  stat;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;

    modport master (
        output icode, ifun, rA, rB, cnd, valE, valM, dmem_error, dbg_sel,
        input  valA, valB, stat, dbg_val
    );

    modport slave (
        input  icode, ifun, rA, rB, cnd, valE, valM, dmem_error, dbg_sel,
        output valA, valB, stat, dbg_val
    );

endinterface

// File: rtl/decode_writeback_regfile.sv
// 15x64 register file: three combinational read ports, two write ports with M priority.
module decode_writeback_regfile
    import y86_defs::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    output logic [63:0] dbg_val,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    logic [63:0] regs [NUM_REGS];

    // RNONE falls outside 0..14, so a write addressed to it matches no entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == int'(RRSP)) ? STACK_INIT : 64'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_m && (dst_m == 4'(i))) begin
                    regs[i] <= val_m;
                end else if (we_e && (dst_e == 4'(i))) begin
                    regs[i] <= val_e;
                end
            end
        end
    end

    assign val_a   = (src_a   == RNONE) ? 64'd0 : regs[src_a];
    assign val_b   = (src_b   == RNONE) ? 64'd0 : regs[src_b];
    assign dbg_val = (dbg_sel == RNONE) ? 64'd0 : regs[dbg_sel];

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode and writeback: register IDs, register file and sticky status.
module decode_writeback
    import y86_defs::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0200
) (
    input logic              clk,
    input logic              rst,
    decode_writeback_if.slave bus
);

    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       wr_en;
    stat_e      stat_q;

    always_comb begin
        src_a = RNONE;
        unique case (bus.icode)
            CMOVXX, RMMOVQ, OPQ, PUSHQ: src_a = bus.rA;
            RET, POPQ:                  src_a = RRSP;
            default:                    src_a = RNONE;
        endcase
    end

    always_comb begin
        src_b = RNONE;
        unique case (bus.icode)
            RMMOVQ, MRMOVQ, OPQ:     src_b = bus.rB;
            CALL, RET, PUSHQ, POPQ:  src_b = RRSP;
            default:                 src_b = RNONE;
        endcase
    end

    // A conditional move that is not taken drops its destination entirely.
    always_comb begin
        dst_e = RNONE;
        unique case (bus.icode)
            CMOVXX:                  dst_e = ((bus.ifun == 4'h0) || bus.cnd) ? bus.rB : RNONE;
            IRMOVQ, OPQ:             dst_e = bus.rB;
            CALL, RET, PUSHQ, POPQ:  dst_e = RRSP;
            default:                 dst_e = RNONE;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        unique case (bus.icode)
            MRMOVQ, POPQ: dst_m = bus.rA;
            default:      dst_m = RNONE;
        endcase
    end

    // The faulting instruction is suppressed at the same edge its status is latched.
    assign wr_en = (stat_q == StatAok) && is_committing(bus.icode) && !bus.dmem_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= StatAok;
        end else if (stat_q == StatAok) begin
            if (bus.icode > POPQ) begin
                stat_q <= StatIns;
            end else if (bus.dmem_error) begin
                stat_q <= StatAdr;
            end else if (bus.icode == HALT) begin
                stat_q <= StatHlt;
            end
        end
    end

    decode_writeback_regfile #(
        .STACK_INIT (STACK_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .src_a   (src_a),
        .src_b   (src_b),
        .dbg_sel (bus.dbg_sel),
        .val_a   (bus.valA),
        .val_b   (bus.valB),
        .dbg_val (bus.dbg_val),
        .we_e    (wr_en),
        .dst_e   (dst_e),
        .val_e   (bus.valE),
        .we_m    (wr_en),
        .dst_m   (dst_m),
        .val_m   (bus.valM)
    );

    assign bus.stat = stat_q;

endmodule
